// File: rtl/mem_6502_ram_pkg.sv
// Shared constants and the byte register type used by the 6502 CPU model,
// its RAM and the bench.
package mem_6502_ram_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;
    localparam int MEM_DEPTH  = 1024;

    // Offset at which program images are placed in the array.
    localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;

    typedef logic [REG_WIDTH-1:0] reg_byte_t;

endpackage

// File: rtl/mem_6502_ram.sv
// Single-port synchronous byte RAM for the 6502 model: read-first, registered read data,
// whole-array preload during reset and a combinational monitor view of the array.
module mem_6502_ram
    import mem_6502_ram_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int WIDTH = REG_WIDTH,
    parameter int AW    = ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] dout,
    input  logic             override_mem,
    input  logic [WIDTH-1:0] mem_override_in [DEPTH],
    output logic [WIDTH-1:0] mem_monitor     [DEPTH]
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             in_range;
    logic [IW-1:0]    idx;

    // Widened compare so DEPTH == 2**AW does not wrap to zero.
    always_comb begin
        in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
        idx      = addr[IW-1:0];
        dout_d   = '0;
        if (!reset && in_range) begin
            dout_d = mem_q[idx];
        end
    end

    // Array is deliberately not cleared by reset; only the preload touches it then.
    always_ff @(posedge clk) begin
        dout_q <= dout_d;
        if (reset) begin
            if (override_mem) begin
                mem_q <= mem_override_in;
            end
        end else if (we && in_range) begin
            mem_q[idx] <= din;
        end
    end

    assign dout        = dout_q;
    assign mem_monitor = mem_q;

endmodule

// File: tb/tb_mem_6502_ram.sv
// Self-checking bench for mem_6502_ram: a behavioural byte-array model predicts dout
// into a scoreboard queue as each cycle is driven; tasks pop and compare.
module tb_mem_6502_ram;
    import mem_6502_ram_pkg::*;

    localparam int D = MEM_DEPTH;

    logic      clk = 1'b0;
    logic      reset;
    logic      we;
    reg_byte_t din;
    logic [ADDR_WIDTH-1:0] addr;
    reg_byte_t dout;
    logic      override_mem;
    reg_byte_t ov_img [D];
    reg_byte_t mon    [D];

    reg_byte_t model  [D];
    reg_byte_t sb     [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_6502_ram dut (
        .clk             (clk),
        .reset           (reset),
        .we              (we),
        .din             (din),
        .addr            (addr),
        .dout            (dout),
        .override_mem    (override_mem),
        .mem_override_in (ov_img),
        .mem_monitor     (mon)
    );

    // Drives one clock of stimulus and pushes the predicted dout for that edge.
    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input reg_byte_t d, input logic ov);
        @(negedge clk);
        reset        = r;
        we           = w;
        addr         = a;
        din          = d;
        override_mem = ov;
        if (r) begin
            sb.push_back(8'h00);
            if (ov) begin
                for (int i = 0; i < D; i++) model[i] = ov_img[i];
            end
        end else begin
            sb.push_back((a < 16'(D)) ? model[a[9:0]] : 8'h00);
            if (w && a < 16'(D)) model[a[9:0]] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reg_byte_t exp;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 16'h0003, 8'h5A, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL reset_dout cycle %0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_preload();
        reg_byte_t exp;
        int bad;
        int first;
        for (int i = 0; i < D; i++) ov_img[i] = reg_byte_t'(i);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL preload_dout cycle %0d: got %h expected %h", k, dout, exp);
            end
        end
        drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 1'b0, 16'h0005, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL preload_read5: got %h expected %h", dout, exp);
        end
        checks++;
        if (mon[5] !== 8'h05) begin
            failures++;
            $display("FAIL preload_mon5: got %h expected 05", mon[5]);
        end
        checks++;
        if (mon[255] !== 8'hFF) begin
            failures++;
            $display("FAIL preload_mon255: got %h expected ff", mon[255]);
        end
        bad = 0;
        first = -1;
        for (int i = 0; i < D; i++) begin
            if (mon[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL preload_image: %0d bad entries, first [%0d] got %h expected %h",
                     bad, first, mon[first], model[first]);
        end
    endtask

    task automatic test_write_read();
        reg_byte_t exp;
        drive(1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL wr_old_data: got %h expected %h", dout, exp);
        end
        checks++;
        if (mon[16] !== 8'hA5) begin
            failures++;
            $display("FAIL wr_monitor16: got %h expected a5", mon[16]);
        end
        drive(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || exp !== 8'hA5) begin
            failures++;
            $display("FAIL wr_readback: got %h expected a5", dout);
        end
    endtask

    task automatic test_collision();
        reg_byte_t exp;
        drive(1'b0, 1'b1, 16'h0020, 8'h11, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 16'h0020, 8'h22, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || exp !== 8'h11) begin
            failures++;
            $display("FAIL collision_read_first: got %h expected 11", dout);
        end
        drive(1'b0, 1'b0, 16'h0020, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || exp !== 8'h22) begin
            failures++;
            $display("FAIL collision_new_data: got %h expected 22", dout);
        end
    endtask

    task automatic test_override_ignored();
        reg_byte_t exp;
        for (int i = 0; i < D; i++) ov_img[i] = 8'h00;
        drive(1'b0, 1'b0, 16'h0005, 8'h00, 1'b1);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL ovr_ignored_read: got %h expected %h", dout, exp);
        end
        checks++;
        if (mon[5] !== 8'h05) begin
            failures++;
            $display("FAIL ovr_ignored_mon5: got %h expected 05", mon[5]);
        end
        override_mem = 1'b0;
        for (int i = 0; i < D; i++) ov_img[i] = reg_byte_t'(i);
    endtask

    task automatic test_out_of_range();
        reg_byte_t exp;
        int bad;
        int first;
        drive(1'b0, 1'b1, 16'hFFFF, 8'h77, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 16'h0400, 8'h99, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 16'h03FF, 8'h3C, 1'b0);
        void'(sb.pop_front());
        bad = 0;
        first = -1;
        for (int i = 0; i < D; i++) begin
            if (mon[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL oor_no_alias: %0d bad entries, first [%0d] got %h expected %h",
                     bad, first, mon[first], model[first]);
        end
        drive(1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || exp !== 8'h00) begin
            failures++;
            $display("FAIL oor_read_ffff: got %h expected 00", dout);
        end
        drive(1'b0, 1'b0, 16'h0400, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL oor_read_0400: got %h expected %h", dout, exp);
        end
        drive(1'b0, 1'b0, 16'h03FF, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || exp !== 8'h3C) begin
            failures++;
            $display("FAIL top_location_read: got %h expected 3c", dout);
        end
    endtask

    task automatic test_back_to_back();
        reg_byte_t exp;
        logic [15:0] a;
        int bad;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            a = 16'($urandom_range(0, 1100));
            drive(1'b0, 1'($urandom_range(0, 1)), a, reg_byte_t'($urandom), 1'b0);
            exp = sb.pop_front();
            if (dout !== exp) begin
                bad++;
                if (bad == 1)
                    $display("FAIL b2b_read step %0d addr %h: got %h expected %h", k, a, dout, exp);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_total: %0d bad reads, expected 0", bad);
        end
    endtask

    task automatic test_reset_retention();
        reg_byte_t exp;
        int bad;
        int first;
        drive(1'b0, 1'b1, 16'h0030, 8'hC3, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 16'h0030, 8'hEE, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL retention_dout cycle %0d: got %h expected %h", k, dout, exp);
            end
        end
        drive(1'b0, 1'b0, 16'h0030, 8'h00, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (dout !== exp || exp !== 8'hC3) begin
            failures++;
            $display("FAIL retention_read30: got %h expected c3", dout);
        end
        bad = 0;
        first = -1;
        for (int i = 0; i < D; i++) begin
            if (mon[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL retention_image: %0d bad entries, first [%0d] got %h expected %h",
                     bad, first, mon[first], model[first]);
        end
    endtask

    initial begin
        reset        = 1'b1;
        we           = 1'b0;
        din          = '0;
        addr         = '0;
        override_mem = 1'b0;
        for (int i = 0; i < D; i++) begin
            ov_img[i] = '0;
            model[i]  = 'x;
        end
        test_reset();
        test_preload();
        test_write_read();
        test_collision();
        test_override_ignored();
        test_out_of_range();
        test_back_to_back();
        test_reset_retention();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
